// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported 32-bit data memory.
// Requester 0 is the CPU data port, requester 1 the loader/DMA. Each access
// takes exactly three cycles: grant (IDLE), memory strobe (ACCESS), response
// (RESP). Ties are broken round-robin via the Last pointer.
module mem_arbiter #(
   parameter int DEPTH_WORDS = 8000
) (
   input  logic        clk,
   input  logic        rst,            // asynchronous, active-low
   input  logic        Req0,
   input  logic        Req1,
   input  logic        Wr0,
   input  logic        Wr1,
   input  logic [31:0] Addr0,
   input  logic [31:0] Addr1,
   input  logic [31:0] WData0,
   input  logic [31:0] WData1,
   output logic        Gnt0,
   output logic        Gnt1,
   output logic        Done0,
   output logic        Done1,
   output logic [31:0] Read_Data,
   output logic        Err,
   output logic        Busy,
   output logic [31:0] Mem_Address,
   output logic [31:0] Mem_Write_Data,
   output logic        Mem_Read,
   output logic        Mem_Write,
   input  logic [31:0] Mem_Read_Data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic        last_q, last_d;      // last granted requester; also owns the current access
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        winner;
   logic        gnt0_c, gnt1_c;
   logic        done0_c, done1_c;
   logic        mem_rd_c, mem_wr_c;
   logic        in_range;

   // Word index is the byte address with the two low bits dropped.
   assign in_range = ({2'b00, addr_q[31:2]} < DEPTH_LIMIT);

   // Next-state, arbitration and strobe decode; every output defaults low.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      winner   = 1'b0;
      gnt0_c   = 1'b0;
      gnt1_c   = 1'b0;
      done0_c  = 1'b0;
      done1_c  = 1'b0;
      mem_rd_c = 1'b0;
      mem_wr_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               // On a tie the requester that did not win last time goes first.
               winner  = (Req0 && Req1) ? ~last_q : Req1;
               state_d = ACCESS;
               last_d  = winner;
               if (winner) begin
                  gnt1_c  = 1'b1;
                  wr_d    = Wr1;
                  addr_d  = Addr1;
                  wdata_d = WData1;
               end else begin
                  gnt0_c  = 1'b1;
                  wr_d    = Wr0;
                  addr_d  = Addr0;
                  wdata_d = WData0;
               end
            end
         end

         ACCESS: begin
            state_d = RESP;
            if (in_range) begin
               mem_wr_c = wr_q;
               mem_rd_c = ~wr_q;
               // A write leaves Read_Data at zero so stale read data never
               // appears alongside a write completion.
               rdata_d  = wr_q ? 32'd0 : Mem_Read_Data;
               err_d    = 1'b0;
            end else begin
               rdata_d  = 32'd0;
               err_d    = 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
            done0_c = ~last_q;
            done1_c = last_q;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and request latches; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Grants are decoded from live requests in IDLE, so they are masked while
   // reset is held; the other pulses already fall to zero via state_q.
   assign Gnt0           = gnt0_c & rst;
   assign Gnt1           = gnt1_c & rst;
   assign Done0          = done0_c;
   assign Done1          = done1_c;
   assign Mem_Read       = mem_rd_c;
   assign Mem_Write      = mem_wr_c;
   assign Mem_Address    = addr_q;
   assign Mem_Write_Data = wdata_q;
   assign Read_Data      = rdata_q;
   assign Err            = err_q;
   assign Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 8000-word memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        Req0, Req1, Wr0, Wr1;
   logic [31:0] Addr0, Addr1, WData0, WData1;
   logic        Gnt0, Gnt1, Done0, Done1;
   logic [31:0] Read_Data;
   logic        Err, Busy;
   logic [31:0] Mem_Address, Mem_Write_Data;
   logic        Mem_Read, Mem_Write;
   logic [31:0] Mem_Read_Data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:7999];
   logic        mem_clear;
   logic [29:0] mem_idx;

   mem_arbiter #(.DEPTH_WORDS(8000)) dut (
      .clk(clk), .rst(rst),
      .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
      .Read_Data(Read_Data), .Err(Err), .Busy(Busy),
      .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data),
      .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
      .Mem_Read_Data(Mem_Read_Data)
   );

   always #5 clk = ~clk;

   assign mem_idx = Mem_Address[31:2];

   // Behavioural memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 8000; i++) mem[i] <= 32'd0;
      end else if (Mem_Write && mem_idx < 30'd8000) begin
         mem[mem_idx[12:0]] <= Mem_Write_Data;
      end
   end

   always_comb begin
      Mem_Read_Data = 32'd0;
      if (mem_idx < 30'd8000) Mem_Read_Data = mem[mem_idx[12:0]];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One complete access from IDLE, checking grant, strobe and response
   // cycles. Starts and ends just after a rising edge with the FSM in IDLE.
   task automatic access(input string tag, input logic who, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic exp_strobe);
      if (who) begin
         Req1 = 1'b1; Wr1 = wr; Addr1 = addr; WData1 = wdata;
      end else begin
         Req0 = 1'b1; Wr0 = wr; Addr0 = addr; WData0 = wdata;
      end
      @(negedge clk);
      check_eq({tag, ".gnt"}, {30'd0, Gnt1, Gnt0}, who ? 32'd2 : 32'd1);
      next_cycle();
      Req0 = 1'b0; Req1 = 1'b0;
      @(negedge clk);
      check_eq({tag, ".strobe"}, {30'd0, Mem_Write, Mem_Read},
               exp_strobe ? (wr ? 32'd2 : 32'd1) : 32'd0);
      check_eq({tag, ".addr"}, Mem_Address, addr);
      check_eq({tag, ".busy"}, {31'd0, Busy}, 32'd1);
      next_cycle();
      @(negedge clk);
      check_eq({tag, ".done"}, {30'd0, Done1, Done0}, who ? 32'd2 : 32'd1);
      check_eq({tag, ".rdata"}, Read_Data, exp_rd);
      check_eq({tag, ".err"}, {31'd0, Err}, {31'd0, exp_err});
      $display("[TB] %s: who=%0d wr=%0d addr=%0d rdata=0x%08h err=%0d",
               tag, who, wr, addr, Read_Data, Err);
      next_cycle();
   endtask

   initial begin
      rst = 1'b0; mem_clear = 1'b1;
      Req0 = 1'b1; Req1 = 1'b1; Wr0 = 1'b1; Wr1 = 1'b0;
      Addr0 = 32'd2000; Addr1 = 32'd0; WData0 = 32'h2A; WData1 = 32'd0;
      repeat (2) next_cycle();
      mem_clear = 1'b0;

      // Reset state with both requests asserted: nothing may escape.
      check_eq("rst.gnt",   {30'd0, Gnt1, Gnt0}, 32'd0);
      check_eq("rst.busy",  {31'd0, Busy}, 32'd0);
      check_eq("rst.rdata", Read_Data, 32'd0);
      check_eq("rst.err",   {31'd0, Err}, 32'd0);
      check_eq("rst.addr",  Mem_Address, 32'd0);
      check_eq("rst.strb",  {30'd0, Mem_Write, Mem_Read}, 32'd0);
      $display("[TB] reset state checked");
      Req0 = 1'b0; Req1 = 1'b0;
      rst = 1'b1;

      access("wr500",    1'b0, 1'b1, 32'd2000,  32'h2A,   32'd0,    1'b0, 1'b1);
      check_eq("mem500", mem[500], 32'd42);
      access("rd500",    1'b1, 1'b0, 32'd2000,  32'd0,    32'd42,   1'b0, 1'b1);
      access("wr7999",   1'b1, 1'b1, 32'd31996, 32'h1234, 32'd0,    1'b0, 1'b1);
      access("rd7999",   1'b0, 1'b0, 32'd31996, 32'd0,    32'h1234, 1'b0, 1'b1);
      access("rd500lo",  1'b0, 1'b0, 32'd2003,  32'd0,    32'd42,   1'b0, 1'b1);
      access("rd8000",   1'b0, 1'b0, 32'd32000, 32'd0,    32'd0,    1'b1, 1'b0);
      access("rd500ok",  1'b1, 1'b0, 32'd2000,  32'd0,    32'd42,   1'b0, 1'b1);

      // Req1 raised mid-access for requester 0 must be granted right after Done0.
      Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'd0;
      @(negedge clk);
      check_eq("late.gnt0", {31'd0, Gnt0}, 32'd1);
      next_cycle();
      Req0 = 1'b0; Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 32'd2000;
      @(negedge clk);
      check_eq("late.acc_gnt1", {31'd0, Gnt1}, 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("late.done0", {30'd0, Done1, Done0}, 32'd1);
      check_eq("late.resp_gnt1", {31'd0, Gnt1}, 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("late.gnt1", {30'd0, Gnt1, Gnt0}, 32'd2);
      next_cycle();
      Req1 = 1'b0;
      next_cycle();
      @(negedge clk);
      check_eq("late.done1", {30'd0, Done1, Done0}, 32'd2);
      check_eq("late.rdata", Read_Data, 32'd42);
      $display("[TB] late Req1 served after Done0, rdata=0x%08h", Read_Data);
      next_cycle();

      // Reset in ACCESS of a write to word 501: the write must be suppressed.
      Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 32'd2004; WData0 = 32'hFFFF_FFFF;
      @(negedge clk);
      check_eq("rstacc.gnt0", {31'd0, Gnt0}, 32'd1);
      next_cycle();
      Req0 = 1'b0;
      #1;
      check_eq("rstacc.wr_before", {31'd0, Mem_Write}, 32'd1);
      rst = 1'b0;
      #1;
      check_eq("rstacc.wr_after", {31'd0, Mem_Write}, 32'd0);
      check_eq("rstacc.busy", {31'd0, Busy}, 32'd0);
      check_eq("rstacc.addr", Mem_Address, 32'd0);
      @(negedge clk);
      check_eq("rstacc.done", {30'd0, Done1, Done0}, 32'd0);
      next_cycle();
      check_eq("rstacc.mem501", mem[501], 32'd0);
      $display("[TB] reset during write access, mem[501]=0x%08h", mem[501]);

      // Both requesters held from reset: grants 0,1,0,1 every third cycle.
      Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 32'd2000;
      Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 32'd31996;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rr.k%0d.c%0d", k, c), {30'd0, Gnt1, Gnt0},
                     (c != 0) ? 32'd0 : ((k % 2 == 0) ? 32'd1 : 32'd2));
            if (c == 0) $display("[TB] round-robin grant %0d: Gnt0=%0d Gnt1=%0d", k, Gnt0, Gnt1);
            next_cycle();
         end
      end
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (2) next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, 8000, number of 32-bit words in the attached data memory; legal word indices are 0..DEPTH_WORDS-1.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Req0, Req1  input  1 each  access request from requester 0 (CPU data port) and requester 1 (loader/DMA).
REQ-005 Wr0, Wr1  input  1 each  1 = write, 0 = read; qualified by ReqN.
REQ-006 Addr0, Addr1  input  32 each  byte address; bits [31:2] give the word index, bits [1:0] are ignored.
REQ-007 WData0, WData1  input  32 each  write data.
REQ-008 Gnt0, Gnt1  output  1 each  one-cycle pulse: request accepted, requester fields captured.
REQ-009 Done0, Done1  output  1 each  one-cycle pulse: access complete; Read_Data and Err valid this cycle.
REQ-010 Read_Data  output  32  read result, shared by both requesters, qualified by DoneN.
REQ-011 Err  output  1  out-of-range word index, qualified by DoneN.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 Mem_Address, Mem_Write_Data  output  32 each  memory address (byte address) and write data.
REQ-014 Mem_Read, Mem_Write  output  1 each  memory strobes.
REQ-015 Mem_Read_Data  input  32  combinational read data returned by the memory.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any request, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-017 In IDLE with exactly one ReqN high, the block SHALL grant that requester.
REQ-018 In IDLE with both requests high, the block SHALL grant the requester that was not granted last (round-robin); the Last pointer resets to 1, so requester 0 wins the first tie.
REQ-019 On the grant edge, the block SHALL latch WrN, AddrN and WData of the winner, pulse GntN for exactly the IDLE cycle in which it is granted, and update Last to the winner.
REQ-020 Requesters SHALL hold ReqN and all fields stable until GntN; after GntN they may change freely.
REQ-021 A ReqN still high in the cycle after DoneN SHALL be treated as a new request.
REQ-022 In ACCESS with an in-range index: drive Mem_Address and Mem_Write_Data from the latches; assert Mem_Write=1 for a write or Mem_Read=1 for a read; capture Mem_Read_Data into Read_Data at the ACCESS->RESP edge on a read.
REQ-023 In ACCESS with latched index >= DEPTH_WORDS: assert neither strobe, set Read_Data=0, set Err=1.
REQ-024 In RESP, the block SHALL pulse DoneN of the granted requester.
REQ-025 Read_Data SHALL hold its value until the next completed read or error, and SHALL be 0 after a write.
REQ-026 Err SHALL be 0 in RESP for in-range accesses.
REQ-027 Latency SHALL be: grant at cycle t (IDLE), memory strobe at t+1, DoneN at t+2; one access per 3 cycles maximum.
REQ-028 Outside ACCESS, Mem_Read and Mem_Write SHALL be 0; Mem_Address and Mem_Write_Data hold the latched values.
REQ-029 Requests arriving in ACCESS or RESP SHALL be ignored until the FSM returns to IDLE; they are not lost while ReqN stays high.
REQ-030 GntN and DoneN SHALL never be high for both requesters in the same cycle.

Reset
REQ-031 While rst=0, the block SHALL immediately (asynchronously) force: state=IDLE, Last=1, all latches=0, and all outputs 0 (Gnt*, Done*, Read_Data, Err, Busy, Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data).
REQ-032 Reset asserted during ACCESS SHALL drop Mem_Write before the next edge, so no write occurs, and no DoneN is issued.
REQ-033 After rst rises, the first grant SHALL occur on the first posedge with ReqN high.

Verification
REQ-034 Req0=1, Wr0=1, Addr0=2000 (word 500), WData0=0x0000002A -> Gnt0 at t, Mem_Write=1 with Mem_Address=2000 at t+1, Done0 at t+2, memory word 500 = 42.
REQ-035 Then Req1=1, Wr1=0, Addr1=2000 -> Done1 at t+2, Read_Data=42, Err=0.
REQ-036 Req0 and Req1 held high together from reset -> grants in the order 0,1,0,1, each 3 cycles apart, never both in one cycle.
REQ-037 Req0 read at Addr0=32000 (index 8000) -> no Mem_Read and no Mem_Write pulse, Done0 with Err=1 and Read_Data=0.
REQ-038 rst driven low in ACCESS of a write of 0xFFFFFFFF to word 501 -> Mem_Write falls immediately, word 501 is unchanged, no Done, Busy=0.
REQ-039 Req1 raised while Busy, during an access for requester 0 -> Gnt1 is issued in the IDLE cycle right after Done0.
